// File: rtl/prog_loader.sv
// prog_loader: streams a program image (LEN, D[0..N-1], CK) byte by byte into
// the program memory write port, holding the CPU in reset until the image has
// been received with a good checksum plus HOLD_CYCLES settling cycles.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   in_valid   byte source presents in_data
//   in_data    stream byte
//   in_ready   loader accepts; transfer when in_valid && in_ready at clk
//   wr_en      program memory write strobe (one cycle per data byte)
//   wr_addr    program memory write address
//   wr_data    program memory write data
//   cpu_reset  CPU reset, low only while running
//   done       image loaded and CPU running
//   error      last image failed its checksum
module prog_loader #(
  parameter logic [7:0]  START_ADDR  = 8'h00,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    len_q, len_d;      // N, 1..256
  logic [8:0]    index_q, index_d;  // bytes written so far in this image
  logic [7:0]    sum_q, sum_d;
  logic [HW-1:0] hold_q, hold_d;

  logic       in_ready_q, in_ready_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       xfer;
  logic [7:0] ck_sum;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    index_d   = index_q;
    sum_d     = sum_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ck_sum    = sum_q + in_data;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (xfer) begin
          len_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          index_d = '0;
          sum_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = START_ADDR + index_q[7:0];
          wr_data_d = in_data;
          sum_d     = ck_sum;
          index_d   = index_q + 9'd1;
          // Counting up against N replaces a separate remaining counter.
          if (index_q == len_q - 9'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = (ck_sum == '0) ? S_HOLD : S_ERROR;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_RUN;
        else              hold_d  = hold_q - HW'(1);
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered decodes of the next state, so they
    // change on the same edge as the state and never glitch.
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD) ||
                  (state_d == S_CHECK) || (state_d == S_ERROR);
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      index_q     <= '0;
      sum_q       <= '0;
      hold_q      <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= START_ADDR;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      index_q     <= index_d;
      sum_q       <= sum_d;
      hold_q      <= hold_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives byte streams into two loaders (START_ADDR 00 and FE)
// and checks every memory write and status output against a reference model
// built from the stream format rules.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready0, wr_en0, cpu_reset0, done0, error0;
  logic [7:0] wr_addr0, wr_data0;
  logic       in_ready1, wr_en1, cpu_reset1, done1, error1;
  logic [7:0] wr_addr1, wr_data1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [7:0]  img[$];
  bit          seen[256];
  int unsigned wr_cnt0 = 0;

  always #5 clk = ~clk;

  prog_loader #(.START_ADDR(8'h00), .HOLD_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_reset(cpu_reset0), .done(done0), .error(error0)
  );

  prog_loader #(.START_ADDR(8'hFE), .HOLD_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .cpu_reset(cpu_reset1), .done(done1), .error(error1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: each strobe must match the next expected (addr,data).
  always @(negedge clk) begin
    if (wr_en0 === 1'b1) begin
      wr_cnt0++;
      seen[wr_addr0] = 1'b1;
      chk("wr0_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) chk("wr0", {wr_addr0, wr_data0}, q0.pop_front());
    end
    if (wr_en1 === 1'b1) begin
      chk("wr1_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) chk("wr1", {wr_addr1, wr_data1}, q1.pop_front());
    end
  end

  task automatic check_reset_vals();
    chk("rst0", {in_ready0, wr_en0, cpu_reset0, done0, error0, wr_addr0, wr_data0},
        {5'b00100, 8'h00, 8'h00});
    chk("rst1", {in_ready1, wr_en1, cpu_reset1, done1, error1, wr_addr1, wr_data1},
        {5'b00100, 8'hFE, 8'h00});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {in_ready0, in_ready1}, 2'b11);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input bit gap);
    int unsigned w;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (in_ready0 !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", in_ready0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_good(input bit poke);
    for (int k = 0; k < 4; k++) begin
      chk("hold_status", {cpu_reset0, done0, in_ready0, cpu_reset1, done1, in_ready1},
          6'b100_100);
      if (poke) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
    end
    chk("run_status", {cpu_reset0, done0, in_ready0, error0, cpu_reset1, done1, in_ready1, error1},
        8'b0100_0100);
    if (poke) begin
      for (int k = 0; k < 5; k++) begin
        in_data = 8'($urandom);
        @(negedge clk);
        chk("run_stays", {in_ready0, done0, cpu_reset0}, 3'b010);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_bad();
    chk("err_status", {error0, cpu_reset0, done0, in_ready0, error1, done1},
        6'b1101_10);
  endtask

  // Model: expected writes are D[i] at START+i mod 256; good iff
  // (sum of D + CK) mod 256 == 0.
  task automatic send_image(input logic [7:0] ck, input bit gap, input bit poke);
    int unsigned s;
    bit good;
    s = 0;
    foreach (img[i]) begin
      q0.push_back({8'(8'h00 + i), img[i]});
      q1.push_back({8'(8'hFE + i), img[i]});
      s += img[i];
    end
    good = ((s + ck) % 256) == 0;
    send(8'(img.size()), gap);
    foreach (img[i]) send(img[i], gap);
    send(ck, gap);
    if (good) check_good(poke);
    else      check_bad();
  endtask

  task automatic rand_img(input int unsigned n);
    img.delete();
    for (int unsigned i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] good_ck();
    int unsigned s;
    s = 0;
    foreach (img[i]) s += img[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  initial begin
    int unsigned cnt_before, distinct;
    logic [7:0] ck;

    // Reset state and first ready cycle
    do_reset();

    // 1: good 3-byte image
    img = '{8'h11, 8'h22, 8'h33};
    send_image(8'h9A, 1'b0, 1'b0);

    // 2: bad checksum, then recover with a good 1-byte image
    do_reset();
    img = '{8'h11, 8'h22, 8'h33};
    send_image(8'h00, 1'b0, 1'b0);
    send(8'h01, 1'b0);
    chk("err_clear", {error0, error1, in_ready0, cpu_reset0}, 4'b0011);
    q0.push_back({8'h00, 8'h05});
    q1.push_back({8'hFE, 8'h05});
    send(8'h05, 1'b0);
    send(8'hFB, 1'b0);
    check_good(1'b0);

    // 3: LEN=0 means 256 bytes, every address once
    do_reset();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    foreach (seen[i]) seen[i] = 1'b0;
    cnt_before = wr_cnt0;
    send_image(8'h80, 1'b0, 1'b0);
    distinct = 0;
    foreach (seen[i]) if (seen[i]) distinct++;
    chk("full_wr_count", wr_cnt0 - cnt_before, 256);
    chk("full_distinct", distinct, 256);

    // 4: address wrap on the FE instance
    do_reset();
    img = '{8'hA1, 8'hB2, 8'hC3};
    send_image(good_ck(), 1'b0, 1'b0);

    // 5: random images with idle gaps, pokes during HOLD/RUN, bad image recovery
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_img($urandom_range(1, 40));
      send_image(good_ck(), 1'b1, 1'b1);
    end
    do_reset();
    rand_img($urandom_range(1, 20));
    ck = good_ck() ^ 8'($urandom_range(1, 255));
    send_image(ck, 1'b1, 1'b0);
    rand_img($urandom_range(1, 20));
    send_image(good_ck(), 1'b1, 1'b1);

    // 6: reset after 2 of 5 data bytes, then a full image from START_ADDR
    do_reset();
    rand_img(5);
    send(8'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      q0.push_back({8'(i), img[i]});
      q1.push_back({8'(8'hFE + i), img[i]});
      send(img[i], 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", in_ready0, 1'b1);
    rand_img(5);
    send_image(good_ck(), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
